int_to_float16_converter: RTL
=============================

// Module: int_to_float16_converter
// PURPOSE
//  Sequential signed-integer to IEEE-754 binary16 encoder; produces operands in the exact packing
//  consumed by the float16 datapath ({sign, exp[4:0], frac[9:0]}, bias 15, hidden bit when exp!=0).
//  Normalises by shifting one bit per cycle (no priority encoder). Truncates toward zero, matching
//  the datapath adder. Valid/ready on both sides; one conversion in flight.
// PARAMETERS
//  INT_W    16   width of signed two's-complement input; legal range 2..32
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      int_in is valid
//  in_ready   out  1      converter can accept (state==IDLE)
//  int_in     in   INT_W  signed integer operand
//  out_valid  out  1      f16_out/of are valid
//  out_ready  in   1      consumer accepts result
//  f16_out    out  16     binary16 result
//  of         out  1      magnitude >= 65536; f16_out = signed infinity
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, out_valid=0, f16_out=16'h0000, of=0; in_ready=1 (from IDLE)
//   but no handshake is taken while rst_n is low. Reset mid-conversion discards the operand.
//  States: IDLE -> NORM -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready: sign<=int_in[INT_W-1]; mag<=|int_in| as INT_W-bit
//   unsigned (most-negative value gives 2^(INT_W-1), no overflow in INT_W bits); sh<=0; ->NORM.
//  NORM: in_ready=0. Each edge: if mag!=0 and mag[INT_W-1]==0: mag<=mag<<1, sh<=sh+1.
//   Otherwise compose result, out_valid<=1, ->DONE.
//  Compose: mag==0 -> f16_out=16'h0000 (sign dropped, never -0), of=0.
//   else p=INT_W-1-sh (bit position of leading one).
//   p>=16 -> f16_out={sign,5'h1F,10'h0}, of=1.
//   p<=15 -> f16_out={sign, 5'(p+15), frac}, of=0; frac=mag[INT_W-2 -: 10], bits below INT_W-2-9
//    discarded (truncation); for INT_W<11 frac is mag[INT_W-2:0] left-aligned, zero-padded.
//   Integers never produce subnormals (min nonzero exponent field = 15).
//  Latency: acceptance edge = edge 1; out_valid rises after edge lz+2, lz = leading zeros of mag
//   (lz:=0 for zero). Range 2 .. INT_W+1 edges.
//  DONE: in_ready=0; f16_out, of, out_valid held stable until out_valid&&out_ready; on that edge
//   out_valid<=0, ->IDLE. Next operand accepted no earlier than the following edge
//   (no same-cycle bypass); max throughput one result per lz+3 cycles.
//  f16_out/of retain last value after handshake; qualify only with out_valid.
//  sh counter width clog2(INT_W)+1; p computed without wrap.
//  Inputs sampled only at the acceptance edge; int_in may change afterwards.
// TESTING
//  1 INT_W=16, int_in=1 -> f16_out=16'h3C00, of=0, out_valid after edge 17 (lz=15).
//  2 int_in=-32768 (16'h8000) -> 16'hF800, of=0, latency 2; int_in=0 -> 16'h0000, latency 2.
//  3 int_in=2049 -> 16'h6800 (truncation); int_in=-3 -> 16'hC200.
//  4 INT_W=32: 65535 -> 16'h7BFF, of=0; 65536 -> 16'h7C00, of=1; -70000 -> 16'hFC00, of=1.
//  5 Backpressure: out_ready=0 for 5 cycles after out_valid -> f16_out stable, in_ready=0,
//    held in_valid not taken; out_ready=1 -> handshake, in_ready=1 next cycle, operand accepted.
//  6 rst_n low during NORM -> out_valid=0, f16_out=0 immediately (async); after release next
//    conversion of 5 -> 16'h4500 with correct latency.

Source files
------------

// File: rtl/int_to_float16_converter.sv
// Sequential signed-integer to binary16 encoder: one-bit-per-cycle normalisation,
// truncating rounding, valid/ready handshake on both sides, one conversion in flight.
module int_to_float16_converter #(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] int_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      f16_out,
  output logic             of
);

  localparam int SHW = $clog2(INT_W) + 1;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           state, state_nxt;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [SHW-1:0]   sh;
  logic             norm_done;
  logic [SHW-1:0]   p_pos;
  logic [INT_W+8:0] frac_ext;
  logic [9:0]       frac;
  logic [15:0]      res;
  logic             res_of;

  assign in_ready  = (state == IDLE);
  assign norm_done = (mag == '0) || mag[INT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Padding below the bits after the leading one left-aligns the fraction for
  // narrow INT_W and truncates the excess for wide INT_W with one slice.
  always_comb begin
    p_pos    = SHW'(INT_W - 1) - sh;
    frac_ext = {mag[INT_W-2:0], 10'b0};
    frac     = frac_ext[INT_W+8 -: 10];
    res      = 16'h0000;
    res_of   = 1'b0;
    if (mag != '0) begin
      if (32'(p_pos) >= 32'd16) begin
        res    = {sign, 5'h1F, 10'h000};
        res_of = 1'b1;
      end else begin
        res = {sign, 5'(32'(p_pos) + 32'd15), frac};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      mag       <= '0;
      sh        <= '0;
      out_valid <= 1'b0;
      f16_out   <= 16'h0000;
      of        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= int_in[INT_W-1];
            mag  <= int_in[INT_W-1] ? (~int_in + INT_W'(1)) : int_in;
            sh   <= '0;
          end
        end
        NORM: begin
          if (!norm_done) begin
            mag <= mag << 1;
            sh  <= sh + SHW'(1);
          end else begin
            f16_out   <= res;
            of        <= res_of;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
